// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, drives the instruction-memory address and registers the returned word into IF/ID one cycle later.
// Stall holds the PC and IF/ID, redirect overrides the stall, and a fetched HALT_WORD freezes fetch until the next redirect or reset.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
   parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_target,
   output logic [31:0] o_pc,
   input  logic [31:0] i_instr,
   output logic [31:0] o_if_id_instr,
   output logic [31:0] o_if_id_pc,
   output logic [31:0] o_if_id_pc_plus4,
   output logic        o_if_id_valid,
   output logic        o_halted,
   output logic        o_misaligned
);

   typedef enum logic {
      ST_FETCH  = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic [31:0] r_instr, w_instr_nxt;
   logic [31:0] r_id_pc, w_id_pc_nxt;
   logic [31:0] r_id_pc4, w_id_pc4_nxt;
   logic        r_valid, w_valid_nxt;
   logic        r_misal, w_misal_nxt;
   logic [31:0] w_pc_plus4;

   assign w_pc_plus4 = r_pc + 32'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_FETCH;
         r_pc     <= RESET_PC;
         r_instr  <= NOP_WORD;
         r_id_pc  <= 32'd0;
         r_id_pc4 <= 32'd0;
         r_valid  <= 1'b0;
         r_misal  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_instr  <= w_instr_nxt;
         r_id_pc  <= w_id_pc_nxt;
         r_id_pc4 <= w_id_pc4_nxt;
         r_valid  <= w_valid_nxt;
         r_misal  <= w_misal_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_instr_nxt  = r_instr;
      w_id_pc_nxt  = r_id_pc;
      w_id_pc4_nxt = r_id_pc4;
      w_valid_nxt  = r_valid;
      w_misal_nxt  = 1'b0;

      if (i_redirect) begin
         // Low target bits are dropped; the flag lets the core raise an exception.
         w_state_nxt  = ST_FETCH;
         w_pc_nxt     = {i_redirect_target[31:2], 2'b00};
         w_instr_nxt  = NOP_WORD;
         w_id_pc_nxt  = 32'd0;
         w_id_pc4_nxt = 32'd0;
         w_valid_nxt  = 1'b0;
         w_misal_nxt  = |i_redirect_target[1:0];
      end else if (i_stall) begin
         w_state_nxt = r_state;
      end else if (r_state == ST_HALTED) begin
         w_instr_nxt  = NOP_WORD;
         w_id_pc_nxt  = 32'd0;
         w_id_pc4_nxt = 32'd0;
         w_valid_nxt  = 1'b0;
      end else begin
         w_instr_nxt  = i_instr;
         w_id_pc_nxt  = r_pc;
         w_id_pc4_nxt = w_pc_plus4;
         w_valid_nxt  = 1'b1;
         // The halt word itself goes down the pipe; the PC parks on it.
         if (i_instr == HALT_WORD) begin
            w_state_nxt = ST_HALTED;
         end else begin
            w_pc_nxt = w_pc_plus4;
         end
      end
   end

   assign o_pc             = r_pc;
   assign o_if_id_instr    = r_instr;
   assign o_if_id_pc       = r_id_pc;
   assign o_if_id_pc_plus4 = r_id_pc4;
   assign o_if_id_valid    = r_valid;
   assign o_halted         = (r_state == ST_HALTED);
   assign o_misaligned     = r_misal;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a small combinational instruction memory.
module tb_if_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        i_stall;
   logic        i_redirect;
   logic [31:0] i_redirect_target;
   logic [31:0] o_pc;
   logic [31:0] i_instr;
   logic [31:0] o_if_id_instr;
   logic [31:0] o_if_id_pc;
   logic [31:0] o_if_id_pc_plus4;
   logic        o_if_id_valid;
   logic        o_halted;
   logic        o_misaligned;

   logic [31:0] mem [0:31];
   int          n_checks;
   int          n_errors;

   if_fetch_unit dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_stall          (i_stall),
      .i_redirect       (i_redirect),
      .i_redirect_target(i_redirect_target),
      .o_pc             (o_pc),
      .i_instr          (i_instr),
      .o_if_id_instr    (o_if_id_instr),
      .o_if_id_pc       (o_if_id_pc),
      .o_if_id_pc_plus4 (o_if_id_pc_plus4),
      .o_if_id_valid    (o_if_id_valid),
      .o_halted         (o_halted),
      .o_misaligned     (o_misaligned)
   );

   // Word index from address bits [6:2]: 0xFFFF_FFFC aliases to slot 31.
   assign i_instr = mem[o_pc[6:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] instr,
                           input logic [31:0] pc, input logic [31:0] pc4, input logic valid);
      chk({tag, ".instr"}, o_if_id_instr, instr);
      chk({tag, ".pc"}, o_if_id_pc, pc);
      chk({tag, ".pc4"}, o_if_id_pc_plus4, pc4);
      chk({tag, ".valid"}, {31'd0, o_if_id_valid}, {31'd0, valid});
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | i;
      mem[4] = 32'hFFFF_FFFF;

      rst_n = 1'b0;
      i_stall = 1'b0;
      i_redirect = 1'b0;
      i_redirect_target = 32'd0;
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      tick();

      // Asynchronous reset asserted mid-cycle.
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst.pc", o_pc, 32'h0);
      chk_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
      chk("rst.halted", {31'd0, o_halted}, 32'd0);
      chk("rst.misal", {31'd0, o_misaligned}, 32'd0);
      #1;
      rst_n = 1'b1;

      tick();
      chk_ifid("e1", 32'hA000_0000, 32'h0, 32'h4, 1'b1);
      chk("e1.pc", o_pc, 32'h4);
      tick();
      chk_ifid("e2", 32'hA000_0001, 32'h4, 32'h8, 1'b1);
      chk("e2.pc", o_pc, 32'h8);

      // Two-cycle stall at o_pc=8.
      i_stall = 1'b1;
      tick();
      tick();
      chk("stall.pc", o_pc, 32'h8);
      chk_ifid("stall", 32'hA000_0001, 32'h4, 32'h8, 1'b1);
      i_stall = 1'b0;
      tick();
      chk_ifid("e3", 32'hA000_0002, 32'h8, 32'hC, 1'b1);
      chk("e3.pc", o_pc, 32'hC);

      // Redirect wins over a simultaneous stall.
      i_redirect = 1'b1;
      i_redirect_target = 32'h40;
      i_stall = 1'b1;
      tick();
      i_redirect = 1'b0;
      i_stall = 1'b0;
      chk("rd.pc", o_pc, 32'h40);
      chk_ifid("rd", 32'h0, 32'h0, 32'h0, 1'b0);
      chk("rd.misal", {31'd0, o_misaligned}, 32'd0);
      tick();
      chk_ifid("rd1", 32'hA000_0010, 32'h40, 32'h44, 1'b1);
      chk("rd1.pc", o_pc, 32'h44);

      // Misaligned target: aligned fetch plus a single-cycle flag.
      i_redirect = 1'b1;
      i_redirect_target = 32'h43;
      tick();
      i_redirect = 1'b0;
      chk("mis.pc", o_pc, 32'h40);
      chk("mis.flag", {31'd0, o_misaligned}, 32'd1);
      chk("mis.valid", {31'd0, o_if_id_valid}, 32'd0);
      tick();
      chk("mis.flag2", {31'd0, o_misaligned}, 32'd0);
      chk("mis.ifpc", o_if_id_pc, 32'h40);

      // Halt word sits at 0x10.
      i_redirect = 1'b1;
      i_redirect_target = 32'hC;
      tick();
      i_redirect = 1'b0;
      tick();
      chk_ifid("pre_h", 32'hA000_0003, 32'hC, 32'h10, 1'b1);
      tick();
      chk_ifid("halt", 32'hFFFF_FFFF, 32'h10, 32'h14, 1'b1);
      chk("halt.flag", {31'd0, o_halted}, 32'd1);
      chk("halt.pc", o_pc, 32'h10);
      tick();
      chk_ifid("halt2", 32'h0, 32'h0, 32'h0, 1'b0);
      chk("halt2.flag", {31'd0, o_halted}, 32'd1);
      chk("halt2.pc", o_pc, 32'h10);
      i_redirect = 1'b1;
      i_redirect_target = 32'h0;
      tick();
      i_redirect = 1'b0;
      chk("unh.flag", {31'd0, o_halted}, 32'd0);
      chk("unh.pc", o_pc, 32'h0);
      tick();
      chk_ifid("unh1", 32'hA000_0000, 32'h0, 32'h4, 1'b1);
      chk("unh1.pc", o_pc, 32'h4);

      // PC wraps modulo 2^32.
      i_redirect = 1'b1;
      i_redirect_target = 32'hFFFF_FFFC;
      tick();
      i_redirect = 1'b0;
      chk("wrap.pc0", o_pc, 32'hFFFF_FFFC);
      tick();
      chk_ifid("wrap", 32'hA000_001F, 32'hFFFF_FFFC, 32'h0, 1'b1);
      chk("wrap.pc", o_pc, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
